// File: rtl/alu_bist.sv
// alu_bist: built-in self-test sequencer for the MIPS ALU.
// Drives ten directed vectors, waits SETTLE_CYCLES per vector, then checks the
// ALU response and reports pass/fail, failure count and first failing index.
// Optional macro ALU_BIST_FLAGCHK_EN: also check zero (all vectors) and
// cout/ovf (ADD vectors only); otherwise only the result is checked.
module alu_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  first_fail,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic        alu_cin,
  output logic [2:0]  alu_cmd,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        alu_cout
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd9;
  localparam logic [3:0]       NO_FAIL  = 4'hF;

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_XOR = 3'd2;
  localparam logic [2:0] CMD_SLT = 3'd3;
  localparam logic [2:0] CMD_AND = 3'd4;
  localparam logic [2:0] CMD_NOR = 3'd6;
  localparam logic [2:0] CMD_OR  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       fail_cnt_q, fail_cnt_d;
  logic [3:0]       first_fail_q, first_fail_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             cin_q, cin_d;
  logic [2:0]       cmd_q, cmd_d;

  vec_t             rom_v;
  logic             mismatch_c;
  logic [3:0]       fail_inc_c;

  // Directed vector ROM indexed by the current vector number
  always_comb begin
    rom_v = '0;
    case (idx_q)
      4'd0: rom_v = '{CMD_ADD, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
      4'd1: rom_v = '{CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      4'd2: rom_v = '{CMD_ADD, 32'hFFFF_FFFB, 32'h8000_0000, 32'h7FFF_FFFB, 1'b1, 1'b1, 1'b0};
      4'd3: rom_v = '{CMD_AND, 32'h1F06_3821, 32'h3FFF_0E11, 32'h1F06_0801, 1'b0, 1'b0, 1'b0};
      4'd4: rom_v = '{CMD_OR,  32'h1F06_3821, 32'h3FFF_0E11, 32'h3FFF_3E31, 1'b0, 1'b0, 1'b0};
      4'd5: rom_v = '{CMD_NOR, 32'h1F06_3821, 32'h3FFF_0E11, 32'hC000_C1CE, 1'b0, 1'b0, 1'b0};
      4'd6: rom_v = '{CMD_XOR, 32'h1F06_3821, 32'h3FFF_0E11, 32'h20F9_3630, 1'b0, 1'b0, 1'b0};
      4'd7: rom_v = '{CMD_SUB, 32'h0000_0004, 32'h0000_0003, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      4'd8: rom_v = '{CMD_SLT, 32'h0000_0001, 32'h0400_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      4'd9: rom_v = '{CMD_SLT, 32'h2000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      default: rom_v = '0;
    endcase
  end

  // Response comparison against the current ROM entry
`ifdef ALU_BIST_FLAGCHK_EN
  always_comb begin
    mismatch_c = (alu_res != rom_v.res) || (alu_zero != rom_v.zero);
    if (rom_v.cmd == CMD_ADD) begin
      mismatch_c = mismatch_c || (alu_cout != rom_v.cout) || (alu_ovf != rom_v.ovf);
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{alu_zero, alu_ovf, alu_cout, rom_v.cout, rom_v.ovf, rom_v.zero};

  always_comb begin
    mismatch_c = (alu_res != rom_v.res);
  end
`endif

  assign fail_inc_c = (fail_cnt_q == 4'hF) ? 4'hF : fail_cnt_q + 4'd1;

  // Sequencer next-state and datapath register updates
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    cin_d        = cin_q;
    cmd_d        = cmd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_DRIVE;
          idx_d        = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_cnt_d   = '0;
          first_fail_d = NO_FAIL;
        end
      end
      S_DRIVE: begin
        opa_d   = rom_v.a;
        opb_d   = rom_v.b;
        cmd_d   = rom_v.cmd;
        cin_d   = 1'b0;
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch_c) begin
          fail_cnt_d = fail_inc_c;
          if (first_fail_q == NO_FAIL) begin
            first_fail_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == 4'd0);
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= NO_FAIL;
      opa_q        <= '0;
      opb_q        <= '0;
      cin_q        <= 1'b0;
      cmd_q        <= CMD_ADD;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      cin_q        <= cin_d;
      cmd_q        <= cmd_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_cnt_q;
  assign first_fail = first_fail_q;
  assign alu_opA    = opa_q;
  assign alu_opB    = opb_q;
  assign alu_cin    = cin_q;
  assign alu_cmd    = cmd_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed testbench for alu_bist: two instances (SETTLE_CYCLES 2 and 0), each
// driving a behavioural ALU with selectable injected faults.
module tb_alu_bist;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   mode1 = 0;   // 0 good, 1 res bit0 stuck-at-0, 2 ovf forced 0
  int   mode2 = 0;   // 0 good, 3 response delayed by one cycle
  int   checks = 0;
  int   errors = 0;

  logic        busy1, done1, pass1, cin1;
  logic [3:0]  fc1, ff1;
  logic [31:0] a1, b1;
  logic [2:0]  cmd1;
  logic [34:0] m1;

  logic        busy2, done2, pass2, cin2;
  logic [3:0]  fc2, ff2;
  logic [31:0] a2, b2;
  logic [2:0]  cmd2;
  logic [34:0] m2, dly_q;

  always #5 clk = ~clk;

  // Reference ALU: {cout, ovf, zero, res}
  function automatic logic [34:0] alu_f(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd6: r = ~(a | b);
      3'd7: r = a | b;
      default: r = '0;
    endcase
    return {c, v, (r == 32'd0), r};
  endfunction

  always_comb begin
    m1 = alu_f(cmd1, a1, b1);
    if (mode1 == 1) begin
      m1[0]  = 1'b0;
      m1[32] = (m1[31:0] == 32'd0);
    end
    if (mode1 == 2) m1[33] = 1'b0;
  end

  always_ff @(posedge clk) dly_q <= alu_f(cmd2, a2, b2);
  assign m2 = (mode2 == 3) ? dly_q : alu_f(cmd2, a2, b2);

  alu_bist #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .start(start1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail(ff1),
    .alu_opA(a1), .alu_opB(b1), .alu_cin(cin1), .alu_cmd(cmd1),
    .alu_res(m1[31:0]), .alu_zero(m1[32]), .alu_ovf(m1[33]), .alu_cout(m1[34])
  );

  alu_bist #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start2),
    .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(fc2), .first_fail(ff2),
    .alu_opA(a2), .alu_opB(b2), .alu_cin(cin2), .alu_cmd(cmd2),
    .alu_res(m2[31:0]), .alu_zero(m2[32]), .alu_ovf(m2[33]), .alu_cout(m2[34])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input int sel, input string pfx, input logic eb, input logic ed,
                            input logic ep, input logic [3:0] efc, input logic [3:0] eff);
    chk({pfx, "_busy"}, 32'(sel ? busy2 : busy1), 32'(eb));
    chk({pfx, "_done"}, 32'(sel ? done2 : done1), 32'(ed));
    chk({pfx, "_pass"}, 32'(sel ? pass2 : pass1), 32'(ep));
    chk({pfx, "_fail_count"}, 32'(sel ? fc2 : fc1), 32'(efc));
    chk({pfx, "_first_fail"}, 32'(sel ? ff2 : ff1), 32'(eff));
  endtask

  task automatic chk_reset(input int sel, input string pfx);
    chk_status(sel, pfx, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
    chk({pfx, "_opA"}, sel ? a2 : a1, 32'h0);
    chk({pfx, "_opB"}, sel ? b2 : b1, 32'h0);
    chk({pfx, "_cmd"}, 32'(sel ? cmd2 : cmd1), 32'h0);
    chk({pfx, "_cin"}, 32'(sel ? cin2 : cin1), 32'h0);
  endtask

  // Pulse start (edge 0) and check timing plus final status at edge lat
  task automatic run(input int sel, input int lat, input string pfx,
                     input logic ep, input logic [3:0] efc, input logic [3:0] eff);
    if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    chk({pfx, "_busy_at_start"}, 32'(sel ? busy2 : busy1), 32'd1);
    chk({pfx, "_done_cleared"}, 32'(sel ? done2 : done1), 32'd0);
    @(posedge clk); #1;
    chk({pfx, "_vec0_opA"}, sel ? a2 : a1, 32'h0000_0001);
    repeat (lat - 2) @(posedge clk);
    #1;
    chk({pfx, "_done_early"}, 32'(sel ? done2 : done1), 32'd0);
    @(posedge clk); #1;
    chk_status(sel, pfx, 1'b0, 1'b1, ep, efc, eff);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0, "rst1");
    chk_reset(1, "rst0");
    reset = 1'b0;

    // Correct ALU, default settle time
    run(0, 40, "good", 1'b1, 4'd0, 4'hF);
    chk("hold_cmd", 32'(cmd1), 32'd3);
    chk("hold_opA", a1, 32'h2000_0001);
    chk("hold_opB", b1, 32'h0000_0001);

    // Result bit 0 stuck low: vectors 2,3,4,7,8 expect bit0=1
    mode1 = 1;
    run(0, 40, "stuck0", 1'b0, 4'd5, 4'd2);

    // Overflow flag forced low: only vector 2 expects ovf=1
    mode1 = 2;
`ifdef ALU_BIST_FLAGCHK_EN
    run(0, 40, "ovf0", 1'b0, 4'd1, 4'd2);
`else
    run(0, 40, "ovf0", 1'b1, 4'd0, 4'hF);
`endif
    mode1 = 0;

    // Zero settle time: correct ALU, then one-cycle-late ALU
    run(1, 20, "s0_good", 1'b1, 4'd0, 4'hF);
    mode2 = 3;
    run(1, 20, "s0_late", 1'b0, 4'd9, 4'd0);
    mode2 = 0;

    // Reset mid-run discards partial results
    mode1 = 1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("midrun_partial_fc", 32'(fc1), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset(0, "midrun");
    mode1 = 0;
    run(0, 40, "after_rst", 1'b1, 4'd0, 4'hF);

    // Start held high: ignored while busy, restarts from DONE
    start1 = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy", 32'(busy1), 32'd1);
    repeat (39) @(posedge clk);
    #1;
    chk("hold_no_restart", 32'(done1), 32'd0);
    @(posedge clk); #1;
    chk("hold_done", 32'(done1), 32'd1);
    @(posedge clk); #1;
    chk("restart_done_clr", 32'(done1), 32'd0);
    chk("restart_busy", 32'(busy1), 32'd1);

    // Reset wins over simultaneous start
    reset = 1'b1;
    start1 = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    chk("rst_wins_busy", 32'(busy1), 32'd0);
    reset = 1'b0;
    start1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
